// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract sequencer driving one external W-bit CLA adder, least-significant word first.
// Optional zero/overflow result flags are enabled by defining CLA_SEQ_FLAGS_EN.
module cla_multiword_seq #(
  parameter int WORDS = 4,
  parameter int W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*WORDS-1:0]   op_a,
  input  logic [W*WORDS-1:0]   op_b,
  input  logic                 op_sub,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_cout,
  output logic [W*WORDS-1:0]   res,
  output logic                 res_cout,
  output logic                 res_valid,
  input  logic                 res_ready
`ifdef CLA_SEQ_FLAGS_EN
  ,
  output logic                 res_zero,
  output logic                 res_ovf
`endif
);

  localparam int NB = W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [NB-1:0]   r_a;
  logic [NB-1:0]   r_b;
  logic [NB-1:0]   r_res;
  logic            r_sub;
  logic            r_carry;
  logic            r_res_cout;
  logic [IW-1:0]   r_idx;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode and adder/handshake drive
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    add_a     = {W{1'b0}};
    add_b     = {W{1'b0}};
    add_cin   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
        else          w_next = IDLE;
      end
      RUN: begin
        // subtract is A + ~B + 1: B is inverted here and the +1 enters as the first carry
        add_a   = r_a[r_idx*W +: W];
        add_b   = r_b[r_idx*W +: W] ^ {W{r_sub}};
        add_cin = r_carry;
        if (r_idx == LAST) w_next = DONE;
        else               w_next = RUN;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
        else           w_next = DONE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // operand latch, word index, carry chain and result collection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= {NB{1'b0}};
      r_b        <= {NB{1'b0}};
      r_res      <= {NB{1'b0}};
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
      r_res_cout <= 1'b0;
      r_idx      <= {IW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= op_sub;
            r_carry <= op_sub;
            r_idx   <= {IW{1'b0}};
          end
        end
        RUN: begin
          r_res[r_idx*W +: W] <= add_sum;
          r_carry             <= add_cout;
          r_idx               <= r_idx + IW'(1);
          if (r_idx == LAST) r_res_cout <= add_cout;
        end
        default: begin
        end
      endcase
    end
  end

  assign res      = r_res;
  assign res_cout = r_res_cout;

`ifdef CLA_SEQ_FLAGS_EN
  logic          r_zero;
  logic          r_ovf;
  logic [NB-1:0] w_res_next;

  // full result as it will look once the current word is written
  always_comb begin
    w_res_next = r_res;
    w_res_next[r_idx*W +: W] = add_sum;
  end

  // flags are captured together with the final word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == RUN) && (r_idx == LAST)) begin
      r_zero <= (w_res_next == {NB{1'b0}});
      r_ovf  <= (r_a[NB-1] == (r_b[NB-1] ^ r_sub)) && (add_sum[W-1] != r_a[NB-1]);
    end else begin
      r_zero <= r_zero;
      r_ovf  <= r_ovf;
    end
  end

  assign res_zero = r_zero;
  assign res_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq: behavioural adder, wide-arithmetic reference model,
// directed spec vectors, randomized ops, result hold, mid-run reset and back-to-back throughput.
module tb_cla_multiword_seq;
  localparam int WORDS = 4;
  localparam int W     = 16;
  localparam int N     = W * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_sub;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic [N-1:0] res;
  logic         res_cout;
  logic         res_valid;
  logic         res_ready;
`ifdef CLA_SEQ_FLAGS_EN
  logic         res_zero;
  logic         res_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // the external adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  cla_multiword_seq #(.WORDS(WORDS), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res(res), .res_cout(res_cout),
    .res_valid(res_valid), .res_ready(res_ready)
`ifdef CLA_SEQ_FLAGS_EN
    , .res_zero(res_zero), .res_ovf(res_ovf)
`endif
  );

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic void ref_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                                    output logic [N-1:0] r, output logic c,
                                    output logic z, output logic v);
    logic [N:0] wide;
    if (sub) begin
      r = a - b;
      c = (a >= b);
      v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      r = wide[N-1:0];
      c = wide[N];
      v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
    end
    z = (r == 64'd0);
  endfunction

  // Called #1 after an edge while IDLE; returns the result and accept-to-valid latency (-1 on timeout).
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input int hold,
                        output logic [N-1:0] r, output logic c, output int lat,
                        output logic z, output logic v);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = rnd64(); op_b = rnd64(); op_sub = ~sub;
    lat = 0;
    while (!res_valid && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    if (!res_valid) lat = -1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    r = res; c = res_cout;
`ifdef CLA_SEQ_FLAGS_EN
    z = res_zero; v = res_ovf;
`else
    z = 1'b0; v = 1'b0;
`endif
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; op_a = 64'd0; op_b = 64'd0; op_sub = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", res_valid); else n_pass++;
    n_checks++; if (res !== 64'd0 || res_cout !== 1'b0) $display("FAIL reset_res got=%h/%b exp=0/0", res, res_cout); else n_pass++;
    n_checks++; if ({add_a, add_b, add_cin} !== 33'd0) $display("FAIL reset_add got=%h %h %b exp=0", add_a, add_b, add_cin); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [5] = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF};
    logic [N-1:0] tb [5] = '{64'd1, 64'd1, 64'd7, 64'd5, 64'd1};
    logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] er [5] = '{64'h0000_0000_0001_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h8000_0000_0000_0000};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         ez [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         ev [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] r;
    logic         c, z, v;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], 0, r, c, lat, z, v);
      n_checks++; if (r !== er[i]) $display("FAIL dir%0d_res got=%h exp=%h", i, r, er[i]); else n_pass++;
      n_checks++; if (c !== ec[i]) $display("FAIL dir%0d_cout got=%b exp=%b", i, c, ec[i]); else n_pass++;
      n_checks++; if (lat !== WORDS) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, WORDS); else n_pass++;
`ifdef CLA_SEQ_FLAGS_EN
      n_checks++; if (z !== ez[i]) $display("FAIL dir%0d_zero got=%b exp=%b", i, z, ez[i]); else n_pass++;
      n_checks++; if (v !== ev[i]) $display("FAIL dir%0d_ovf got=%b exp=%b", i, v, ev[i]); else n_pass++;
`endif
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, r, er;
    logic         s, c, z, v, ec, ez, ev;
    int           lat;
    for (int i = 0; i < 30; i++) begin
      a = rnd64(); b = rnd64(); s = 1'($urandom_range(1, 0));
      if (i % 5 == 0) b = a;
      if (i % 7 == 0) a = {32'hFFFF_FFFF, $urandom};
      ref_model(a, b, s, er, ec, ez, ev);
      run_op(a, b, s, $urandom_range(3, 0), r, c, lat, z, v);
      n_checks++; if (r !== er) $display("FAIL rand%0d_res got=%h exp=%h", i, r, er); else n_pass++;
      n_checks++; if (c !== ec) $display("FAIL rand%0d_cout got=%b exp=%b", i, c, ec); else n_pass++;
      n_checks++; if (lat !== WORDS) $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, WORDS); else n_pass++;
`ifdef CLA_SEQ_FLAGS_EN
      n_checks++; if (z !== ez || v !== ev) $display("FAIL rand%0d_flags got=%b%b exp=%b%b", i, z, v, ez, ev); else n_pass++;
`endif
    end
  endtask

  task automatic test_hold();
    logic [N-1:0] a, b, er;
    logic         ec, ez, ev;
    int           n;
    a = rnd64(); b = rnd64();
    ref_model(a, b, 1'b1, er, ec, ez, ev);
    op_a = a; op_b = b; op_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 64) begin
      @(posedge clk); #1; n++;
    end
    n_checks++; if (res_valid !== 1'b1) $display("FAIL hold_reach_done got=%b exp=1", res_valid); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      op_a = rnd64(); op_b = rnd64(); op_sub = 1'($urandom_range(1, 0)); in_valid = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      n_checks++; if (res !== er || res_cout !== ec) $display("FAIL hold%0d_res got=%h/%b exp=%h/%b", k, res, res_cout, er, ec); else n_pass++;
      n_checks++; if (in_ready !== 1'b0 || res_valid !== 1'b1) $display("FAIL hold%0d_hs got=%b%b exp=01", k, in_ready, res_valid); else n_pass++;
    end
    in_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL hold_release got=%b%b exp=10", in_ready, res_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] a, b, r, er;
    logic         c, z, v, ec, ez, ev;
    int           lat;
    op_a = rnd64(); op_b = rnd64(); op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL midrst_hs got=%b%b exp=10", in_ready, res_valid); else n_pass++;
    n_checks++; if (res !== 64'd0 || res_cout !== 1'b0) $display("FAIL midrst_res got=%h/%b exp=0/0", res, res_cout); else n_pass++;
    n_checks++; if ({add_a, add_b, add_cin} !== 33'd0) $display("FAIL midrst_add got=%h %h %b exp=0", add_a, add_b, add_cin); else n_pass++;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    a = rnd64(); b = rnd64();
    ref_model(a, b, 1'b1, er, ec, ez, ev);
    run_op(a, b, 1'b1, 0, r, c, lat, z, v);
    n_checks++; if (r !== er || c !== ec) $display("FAIL midrst_next got=%h/%b exp=%h/%b", r, c, er, ec); else n_pass++;
    n_checks++; if (lat !== WORDS) $display("FAIL midrst_latency got=%0d exp=%0d", lat, WORDS); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_q [$];
    logic [N-1:0] er;
    logic         ec, ez, ev, acc;
    int           acc_cyc [$];
    int           n_done;
    n_done = 0;
    op_a = rnd64(); op_b = rnd64(); op_sub = 1'b0;
    in_valid = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < 3 * (WORDS + 2); k++) begin
      acc = in_ready;
      if (acc) begin
        ref_model(op_a, op_b, op_sub, er, ec, ez, ev);
        exp_q.push_back(er);
        acc_cyc.push_back(k);
      end
      @(posedge clk); #1;
      if (acc) begin
        op_a = rnd64(); op_b = rnd64(); op_sub = 1'($urandom_range(1, 0));
      end
      if (res_valid) begin
        n_done++;
        er = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
        n_checks++; if (res !== er) $display("FAIL b2b_res%0d got=%h exp=%h", n_done, res, er); else n_pass++;
      end
    end
    in_valid = 1'b0; res_ready = 1'b0;
    n_checks++; if (acc_cyc.size() !== 3) $display("FAIL b2b_accepts got=%0d exp=3", acc_cyc.size()); else n_pass++;
    n_checks++; if (n_done !== 3) $display("FAIL b2b_results got=%0d exp=3", n_done); else n_pass++;
    if (acc_cyc.size() >= 2) begin
      n_checks++;
      if (acc_cyc[1] - acc_cyc[0] !== WORDS + 2) $display("FAIL b2b_spacing got=%0d exp=%0d", acc_cyc[1] - acc_cyc[0], WORDS + 2);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
